dsp48a1_mac_sequencer: RTL and testbench

//  Drives one DSP48A1 slice as a streaming signed multiply-accumulate engine.

---
 rtl/dsp48a1_mac_sequencer_if.sv | 42 ++++
 rtl/dsp48a1_mac_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_mac_sequencer_if.sv
// Bundle of control, operand, result and slice-side signals for the DSP48A1 MAC sequencer.
// The master side drives operands and carries the slice P output; the slave side is the sequencer.
interface dsp48a1_mac_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             busy;

  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;

  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea;
  logic             dsp_ceb;
  logic             dsp_cem;
  logic             dsp_ceopmode;
  logic             dsp_cep;
  logic             dsp_rstp;
  logic [47:0]      dsp_p;

  modport master (
    output start, len, abort, in_valid, in_a, in_b, res_ready, dsp_p,
    input  busy, in_ready, res_valid, res_data,
           dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp
  );

  modport slave (
    input  start, len, abort, in_valid, in_a, in_b, res_ready, dsp_p,
    output busy, in_ready, res_valid, res_data,
           dsp_a, dsp_b, dsp_opmode, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Streams a frame of signed 18x18 operand pairs into one DSP48A1 slice and returns the
// 48-bit accumulated sum; a tag pipe schedules OPMODE and CEP to follow each pair through the slice.
module dsp48a1_mac_sequencer #(
  parameter int CNT_W    = 16,
  parameter int OPM_SKEW = 1,
  parameter int P_LAT    = 3
) (
  input logic                    clk,
  input logic                    rst,
  dsp48a1_mac_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] count_reg;
  logic             first_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             res_valid_reg;
  logic [47:0]      res_data_reg;
  logic [17:0]      dsp_a_reg;
  logic [17:0]      dsp_b_reg;
  logic [7:0]       dsp_opmode_reg;
  logic             dsp_cea_reg;
  logic             dsp_ceb_reg;
  logic             dsp_cem_reg;
  logic             dsp_ceopmode_reg;
  logic             dsp_cep_reg;
  logic             dsp_rstp_reg;

  // Bit k of each tag shift register describes the pair issued k cycles ago.
  logic [P_LAT-2:0]    tag_valid_reg;
  logic [OPM_SKEW-1:0] tag_first_reg;
  logic [P_LAT:0]      tag_last_reg;

  logic abort_act;
  logic issue;
  logic last_issue;

  assign abort_act  = bus.abort && (state_reg != IDLE);
  assign issue      = (state_reg == RUN) && in_ready_reg && bus.in_valid && !abort_act;
  assign last_issue = issue && (count_reg == len_reg - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_first_reg <= '0;
      tag_last_reg  <= '0;
    end else if (abort_act) begin
      tag_valid_reg <= '0;
      tag_first_reg <= '0;
      tag_last_reg  <= '0;
    end else begin
      tag_valid_reg <= (tag_valid_reg << 1) | (P_LAT-1)'(issue);
      tag_first_reg <= (tag_first_reg << 1) | OPM_SKEW'(issue && first_reg);
      tag_last_reg  <= (tag_last_reg << 1) | (P_LAT+1)'(last_issue);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      len_reg          <= '0;
      count_reg        <= '0;
      first_reg        <= 1'b0;
      in_ready_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_data_reg     <= '0;
      dsp_a_reg        <= '0;
      dsp_b_reg        <= '0;
      dsp_opmode_reg   <= '0;
      dsp_cea_reg      <= 1'b0;
      dsp_ceb_reg      <= 1'b0;
      dsp_cem_reg      <= 1'b0;
      dsp_ceopmode_reg <= 1'b0;
      dsp_cep_reg      <= 1'b0;
      dsp_rstp_reg     <= 1'b0;
    end else begin
      dsp_cea_reg  <= issue;
      dsp_ceb_reg  <= issue;
      dsp_rstp_reg <= 1'b0;
      dsp_cep_reg  <= tag_valid_reg[P_LAT-2];
      if (issue) begin
        dsp_a_reg <= bus.in_a;
        dsp_b_reg <= bus.in_b;
      end
      // First pair of a frame loads M alone (Z=0) so residual P never leaks in.
      dsp_opmode_reg <= (state_reg == IDLE) ? 8'h00 :
                        (tag_first_reg[OPM_SKEW-1] ? 8'h01 : 8'h09);

      if (abort_act) begin
        state_reg        <= IDLE;
        in_ready_reg     <= 1'b0;
        busy_reg         <= 1'b0;
        res_valid_reg    <= 1'b0;
        dsp_cem_reg      <= 1'b0;
        dsp_ceopmode_reg <= 1'b0;
        dsp_cep_reg      <= 1'b0;
        dsp_opmode_reg   <= 8'h00;
        dsp_rstp_reg     <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start && (bus.len != '0)) begin
              state_reg        <= RUN;
              len_reg          <= bus.len;
              count_reg        <= '0;
              first_reg        <= 1'b1;
              in_ready_reg     <= 1'b1;
              busy_reg         <= 1'b1;
              dsp_cem_reg      <= 1'b1;
              dsp_ceopmode_reg <= 1'b1;
            end
          end
          RUN: begin
            if (issue) begin
              count_reg <= count_reg + CNT_W'(1);
              first_reg <= 1'b0;
              if (last_issue) begin
                state_reg    <= DRAIN;
                in_ready_reg <= 1'b0;
              end
            end
          end
          DRAIN: begin
            // The last pair's product is on dsp_p once its tag has aged P_LAT cycles.
            if (tag_last_reg[P_LAT]) begin
              res_data_reg  <= bus.dsp_p;
              res_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
          DONE: begin
            if (bus.res_ready) begin
              res_valid_reg    <= 1'b0;
              state_reg        <= IDLE;
              busy_reg         <= 1'b0;
              dsp_cem_reg      <= 1'b0;
              dsp_ceopmode_reg <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.busy         = busy_reg;
  assign bus.in_ready     = in_ready_reg;
  assign bus.res_valid    = res_valid_reg;
  assign bus.res_data     = res_data_reg;
  assign bus.dsp_a        = dsp_a_reg;
  assign bus.dsp_b        = dsp_b_reg;
  assign bus.dsp_opmode   = dsp_opmode_reg;
  assign bus.dsp_cea      = dsp_cea_reg;
  assign bus.dsp_ceb      = dsp_ceb_reg;
  assign bus.dsp_cem      = dsp_cem_reg;
  assign bus.dsp_ceopmode = dsp_ceopmode_reg;
  assign bus.dsp_cep      = dsp_cep_reg;
  assign bus.dsp_rstp     = dsp_rstp_reg;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Directed bench for the MAC sequencer driving a behavioural DSP48A1 slice
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, C/D/PCIN/CARRYIN tied 0).
module tb_dsp48a1_mac_sequencer;

  localparam int P_LAT = 3;

  logic clk;
  logic rst;

  dsp48a1_mac_sequencer_if #(.CNT_W(16)) bus ();

  dsp48a1_mac_sequencer #(.CNT_W(16), .OPM_SKEW(1), .P_LAT(P_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model; its registers are not touched by rst, as in the real integration.
  logic signed [17:0] a1 = '0;
  logic signed [17:0] b1 = '0;
  logic signed [35:0] m  = '0;
  logic [7:0]         opm = '0;
  logic [47:0]        p  = '0;
  logic [47:0]        xmux;
  logic [47:0]        zmux;

  assign xmux = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
  assign zmux = (opm[3:2] == 2'b10) ? p : 48'd0;

  always @(posedge clk) begin
    if (bus.dsp_cea) a1 <= bus.dsp_a;
    if (bus.dsp_ceb) b1 <= bus.dsp_b;
    if (bus.dsp_cem) m <= a1 * b1;
    if (bus.dsp_ceopmode) opm <= bus.dsp_opmode;
    if (bus.dsp_rstp) p <= '0;
    else if (bus.dsp_cep) p <= zmux + xmux;
  end
  assign bus.dsp_p = p;

  int cep_count = 0;
  always @(posedge clk) if (bus.dsp_cep) cep_count <= cep_count + 1;

  int checks = 0;
  int failures = 0;
  logic signed [17:0] va [8];
  logic signed [17:0] vb [8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pairs(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_a = va[i];
      bus.in_b = vb[i];
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic start_frame(input int n);
    bus.start = 1'b1;
    bus.len = 16'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!bus.res_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_frame(input string tag, input int n, input int gap,
                           input logic [47:0] exp, input bit chk_lat);
    int cycles;
    int cep_base;
    cep_base = cep_count;
    bus.res_ready = 1'b1;
    start_frame(n);
    send_pairs(n, gap);
    wait_result(cycles);
    check_eq({tag, "_valid"}, 64'(bus.res_valid), 64'd1);
    if (chk_lat) check_eq({tag, "_lat"}, 64'(cycles), 64'(P_LAT + 1));
    check_eq({tag, "_data"}, 64'(bus.res_data), 64'(exp));
    $display("frame %s len=%0d gap=%0d res=%h after %0d cycles", tag, n, gap, bus.res_data, cycles);
    tick();
    check_eq({tag, "_idle"}, 64'({bus.res_valid, bus.busy}), 64'd0);
    check_eq({tag, "_cep"}, 64'(cep_count - cep_base), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flags", 64'({bus.busy, bus.in_ready, bus.res_valid, bus.dsp_cea, bus.dsp_ceb,
                               bus.dsp_cem, bus.dsp_ceopmode, bus.dsp_cep, bus.dsp_rstp}), 64'd0);
    check_eq("rst_bus", 64'({bus.dsp_a, bus.dsp_b, bus.dsp_opmode}), 64'd0);
    check_eq("rst_data", 64'(bus.res_data), 64'd0);
    #3 rst = 1'b0;
    tick();

    // basic
    va[0] = 18'sd20; vb[0] = 18'sd10;
    va[1] = 18'sd5;  vb[1] = 18'sd6;
    va[2] = 18'sd3;  vb[2] = 18'sd4;
    run_frame("basic", 3, 0, 48'hF2, 1'b1);

    // signed
    va[0] = -18'sd2; vb[0] = 18'sd3;
    va[1] = -18'sd7; vb[1] = -18'sd8;
    run_frame("signed2", 2, 0, 48'd50, 1'b1);
    va[0] = -18'sd1; vb[0] = 18'sd1;
    run_frame("signed1", 1, 0, 48'hFFFF_FFFF_FFFF, 1'b1);

    // bubbles
    for (int i = 0; i < 3; i++) begin
      va[i] = 18'sd20; vb[i] = 18'sd10;
    end
    run_frame("bubble", 3, 2, 48'h258, 1'b0);

    // back-to-back, first tag must ignore the previous P
    va[0] = 18'sd1; vb[0] = 18'sd1;
    run_frame("b2b", 1, 0, 48'h1, 1'b1);

    // backpressure
    va[0] = 18'sd100; vb[0] = 18'sd100;
    va[1] = -18'sd50; vb[1] = 18'sd4;
    bus.res_ready = 1'b0;
    start_frame(2);
    send_pairs(2, 0);
    wait_result(cycles);
    for (int k = 0; k < 5; k++) begin
      check_eq("hold_valid", 64'(bus.res_valid), 64'd1);
      check_eq("hold_data", 64'(bus.res_data), 64'd9800);
      bus.start = (k == 1);
      bus.len = 16'd5;
      tick();
    end
    bus.start = 1'b0;
    check_eq("hold_no_start", 64'(bus.in_ready), 64'd0);
    $display("frame hold len=2 res=%h held 5 cycles", bus.res_data);
    bus.res_ready = 1'b1;
    tick();
    check_eq("hold_release", 64'({bus.res_valid, bus.busy}), 64'd0);

    // abort mid-RUN
    va[0] = 18'sd100; vb[0] = 18'sd100;
    va[1] = 18'sd100; vb[1] = 18'sd100;
    start_frame(4);
    send_pairs(2, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_idle", 64'({bus.busy, bus.in_ready, bus.res_valid}), 64'd0);
    check_eq("abort_rstp", 64'(bus.dsp_rstp), 64'd1);
    tick();
    check_eq("abort_rstp_end", 64'(bus.dsp_rstp), 64'd0);
    check_eq("abort_p_clear", 64'(bus.dsp_p), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen |= bus.res_valid;
      tick();
    end
    check_eq("abort_no_result", 64'(seen), 64'd0);
    $display("frame abort len=4 cancelled after 2 pairs");
    va[0] = 18'sd2; vb[0] = 18'sd3;
    run_frame("after_abort", 1, 0, 48'd6, 1'b1);

    // reset mid-DRAIN
    va[0] = 18'sd7; vb[0] = 18'sd7;
    va[1] = 18'sd1; vb[1] = 18'sd1;
    start_frame(2);
    send_pairs(2, 0);
    #3 rst = 1'b1;
    #1;
    check_eq("mid_rst_flags", 64'({bus.busy, bus.in_ready, bus.res_valid, bus.dsp_cea, bus.dsp_ceb,
                                   bus.dsp_cem, bus.dsp_ceopmode, bus.dsp_cep, bus.dsp_rstp}), 64'd0);
    check_eq("mid_rst_bus", 64'({bus.dsp_a, bus.dsp_b, bus.dsp_opmode}), 64'd0);
    check_eq("mid_rst_data", 64'(bus.res_data), 64'd0);
    $display("frame reset len=2 interrupted in drain");
    #2 rst = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.len = 16'd0;
    tick();
    bus.start = 1'b0;
    check_eq("len0_ignored", 64'({bus.busy, bus.in_ready}), 64'd0);
    va[0] = 18'sd3; vb[0] = -18'sd3;
    run_frame("after_rst", 1, 0, 48'hFFFF_FFFF_FFF7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
